// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and address-width helper for the multi-port register file
package regfile_pkg;
    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: pending-write busy bits, set on issue and cleared on write
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int NWR   = 1,
    localparam int AW   = addr_w(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_addr,
    input  logic [NWR-1:0]    wr_en,
    input  logic [NWR*AW-1:0] wr_addr,
    output logic [NREGS-1:0]  busy
);
    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_set;
    logic [NREGS-1:0] w_clr;
    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (iss_en) w_set[iss_addr] = 1'b1;
        for (int p = 0; p < NWR; p++)
            if (wr_en[p]) w_clr[wr_addr[p*AW +: AW]] = 1'b1;
    end
    // set applied after clear so a same-edge issue survives the retiring write
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_busy <= '0;
        else        r_busy <= ((r_busy & ~w_clr) | w_set) & ~NREGS'(1);
    assign busy = r_busy;
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with x0 hardwired to zero, registered reads,
// write-to-read bypass and a pending-write scoreboard
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = 2,
    parameter int NWR   = 1,
    localparam int AW   = addr_w(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD-1:0]      rd_en,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_valid,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    output logic [NREGS-1:0]    busy
);
    logic [XLEN-1:0]     r_regs [NREGS];
    logic [NRD*XLEN-1:0] r_rd_data;
    logic [NRD-1:0]      r_rd_valid;
    logic [NRD*XLEN-1:0] w_rd_next;
    // ascending port order makes the highest-index write the last assignment, so it wins
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            for (int n = 0; n < NREGS; n++) r_regs[n] <= '0;
        end else begin
            for (int p = 0; p < NWR; p++)
                if (wr_en[p] && wr_addr[p*AW +: AW] != '0)
                    r_regs[wr_addr[p*AW +: AW]] <= wr_data[p*XLEN +: XLEN];
        end
    always_comb begin
        w_rd_next = '0;
        for (int i = 0; i < NRD; i++) begin
            w_rd_next[i*XLEN +: XLEN] = r_regs[rd_addr[i*AW +: AW]];
            for (int p = 0; p < NWR; p++)
                if (wr_en[p] && wr_addr[p*AW +: AW] == rd_addr[i*AW +: AW])
                    w_rd_next[i*XLEN +: XLEN] = wr_data[p*XLEN +: XLEN];
            if (rd_addr[i*AW +: AW] == '0) w_rd_next[i*XLEN +: XLEN] = '0;
        end
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_rd_data  <= '0;
            r_rd_valid <= '0;
        end else begin
            r_rd_valid <= rd_en;
            for (int i = 0; i < NRD; i++)
                if (rd_en[i]) r_rd_data[i*XLEN +: XLEN] <= w_rd_next[i*XLEN +: XLEN];
        end
    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    regfile_scoreboard #(.NREGS(NREGS), .NWR(NWR)) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .busy     (busy)
    );
endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32, data word width in bits.
REQ-002 SHALL have parameter NREGS, default 32, number of architectural registers (power of two, >= 2); AW = log2(NREGS).
REQ-003 SHALL have parameter NRD, default 2, number of read ports (1..4).
REQ-004 SHALL have parameter NWR, default 1, number of write ports (1..2).
REQ-005 SHALL have port clk  input  1  single clock, all state updates on the rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port rd_en  input  NRD  per-port read request.
REQ-008 SHALL have port rd_addr  input  NRD*AW  packed read addresses, port i at bits [i*AW +: AW].
REQ-009 SHALL have port rd_data  output  NRD*XLEN  packed registered read data.
REQ-010 SHALL have port rd_valid  output  NRD  per-port flag: rd_data slice updated this cycle.
REQ-011 SHALL have port wr_en  input  NWR  per-port write enable.
REQ-012 SHALL have port wr_addr  input  NWR*AW  packed write addresses.
REQ-013 SHALL have port wr_data  input  NWR*XLEN  packed write data.
REQ-014 SHALL have port iss_en  input  1  marks iss_addr as pending (producer issued).
REQ-015 SHALL have port iss_addr  input  AW  destination register being issued.
REQ-016 SHALL have port busy  output  NREGS  registered pending-write scoreboard, bit n = register n.

Function
REQ-017 SHALL hold register 0 at constant zero: writes to address 0 are discarded, reads return 0, busy[0] is always 0.
REQ-018 SHALL commit wr_data to wr_addr on the rising clk edge when the port's wr_en is 1 and wr_addr != 0.
REQ-019 SHALL, when both write ports target the same nonzero address in one cycle, commit port NWR-1 data only (higher index wins).
REQ-020 SHALL provide read latency of exactly one cycle: rd_en sampled at edge k gives rd_data and rd_valid=1 after edge k.
REQ-021 SHALL hold rd_data for a port unchanged and drive its rd_valid to 0 in cycles following an edge where its rd_en was 0.
REQ-022 SHALL bypass writes to reads: a read sampled at the same edge as a write to the same nonzero address returns the new write data (highest winning write port).
REQ-023 SHALL set busy[iss_addr] at the edge where iss_en=1 and iss_addr != 0.
REQ-024 SHALL clear busy[n] at the edge where any enabled write port targets n.
REQ-025 SHALL, when an issue and a write target the same register at the same edge, leave busy set (issue wins: a newer producer exists).
REQ-026 SHALL treat a write to a non-busy register as a normal write with no error indication.

Reset
REQ-027 SHALL, while rst_n=0, asynchronously clear all registers, rd_data, rd_valid and busy to 0, independent of clk.
REQ-028 SHALL discard any write, read or issue sampled at an edge during which rst_n=0; operation resumes at the first rising edge after rst_n deasserts.

Structure
REQ-029 SHALL place XLEN and NREGS defaults and the address-width function in shared package regfile_pkg.
REQ-030 SHALL implement the busy vector in one sub-module, regfile_scoreboard (inputs: iss_en, iss_addr, write enables/addresses; output: busy).
REQ-031 SHALL keep storage, write arbitration and read bypass in regfile_mp itself, with no combinational path from inputs to outputs.

Verification
REQ-032 SHALL cover reset: drive rst_n=0 mid-run with writes pending -> rd_data=0, rd_valid=0, busy=0 immediately, and reading x5 after release returns 0.
REQ-033 SHALL cover x0: write 0xDEADBEEF to address 0, then read port 0 address 0 -> rd_data=0, rd_valid=1, busy[0]=0.
REQ-034 SHALL cover bypass: at the same edge write 0x12345678 to x7 and read x7 on both ports -> both rd_data=0x12345678 one cycle later.
REQ-035 SHALL cover write conflict (NWR=2): port0 writes 0x1111 and port1 writes 0x2222 to x3 at the same edge -> subsequent read of x3 returns 0x2222.
REQ-036 SHALL cover scoreboard: issue x4 -> busy[4]=1 next cycle; issue x4 and write x4 at the same edge -> busy[4] stays 1; write x4 alone -> busy[4]=0.
REQ-037 SHALL cover read hold: rd_en=1 for x2 holding 5, then rd_en=0 while x2 is overwritten with 9 -> rd_data stays 5, rd_valid=0.
